alu_seq: RTL and testbench
==========================

# alu_seq

Control stage directly upstream of the ALU operation circuits. It accepts one decoded instruction per valid/ready handshake and registers its opcode, mode and operands. It drives the ALU for one execute cycle, captures the result and flags, and maintains the 3-bit status register (zero, sign, carry). It then presents the result to register-file writeback through a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, 20: full-word data width; half-word width is WIDTH/2.
- OPW, 5: opcode width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction available
- in_ready  out  1  stage can accept an instruction
- in_op  in  OPW  opcode
- in_mode  in  1  1 = full-word, 0 = half-word
- in_a, in_b  in  WIDTH  operands
- alu_op  out  OPW  registered opcode to ALU
- alu_mode  out  1  registered mode
- alu_a, alu_b  out  WIDTH  registered operands
- alu_cin  out  1  status carry, for ADC/SBC
- alu_c, alu_c2  in  WIDTH  ALU result; alu_c2 is second SWP result
- alu_zero, alu_sign, alu_carry  in  1  ALU flag outputs
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_data, wb_data2  out  WIDTH  result; second result for SWP
- wb_two  out  1  wb_data2 is valid (SWP only)
- status  out  3  {carry, sign, zero}
- trap  out  1  illegal-opcode trap (ALU_SEQ_TRAP_EN only)
- trap_clr  in  1  clears the trap (ALU_SEQ_TRAP_EN only)

## Operation
Opcodes:
- 0 NOP, 1 NOT, 2 AND, 3 OR, 4 XOR
- 5 SHR, 6 SHL, 7 ROR, 8 ROL, 9 SWP
- 10 INC, 11 DEC, 12 ADD, 13 ADC, 14 SUB, 15 SBC
- 16 EQ, 17 GT, 18 LT, 19 GE, 20 LE
- 21 LSR: status <= in_a[2:0]
- 22–31: illegal

FSM states and transitions:
- IDLE: in_ready=1. On handshake, capture op/mode/a/b.
  - NOP and LSR complete in this capture cycle; the state stays IDLE.
  - Illegal opcode goes to TRAP (macro on), else it is treated as NOP.
  - All other opcodes go to EXEC.
- EXEC: ALU inputs are stable from registers. At the clock edge, capture alu_c and alu_c2 into wb_data and wb_data2, and update flags.
  - Compare ops (16–20) go to IDLE and produce no writeback.
  - All others go to WB.
- WB: wb_valid=1; wb_data, wb_data2 and wb_two are held stable. On wb_valid & wb_ready, go to IDLE.
- TRAP: trap=1, in_ready=0. On trap_clr, go to IDLE.

Flag update rules (flags not listed are held):
- Logic ops (1–4): zero.
- SHR, SHL: zero, carry.
- ROR, ROL, SWP: none.
- Arithmetic ops (10–15): zero, carry, and sign. Sign = result bit WIDTH-1 in full mode, bit WIDTH/2-1 in half mode.
- Compare ops: zero and sign exactly as driven by the ALU; carry held.

Reset values: all outputs and all registers are 0; state is IDLE. An asynchronous reset mid-transaction discards the pending instruction and result.

## Timing
- Handshake in cycle N → EXEC in N+1 → wb_valid asserted in N+2.
- Status updated at the end of N+1, visible in N+2.
- Compare ops: in_ready=1 again in N+2.
- Writeback ops: in_ready=1 in the cycle after the wb handshake, so throughput is at most one op per 3 cycles.
- wb_ready low: WB holds indefinitely with outputs unchanged; in_ready stays 0.
- NOP: in_ready remains 1 with no bubble. LSR status is visible in N+1.
- trap_clr is sampled only in TRAP and ignored elsewhere.
- Simultaneous wb handshake and in_valid: the instruction is not accepted until the following cycle.

## Configuration
Macro: ALU_SEQ_TRAP_EN.
- Defined: illegal opcodes enter TRAP, and status is unchanged.
- Undefined: illegal opcodes behave as NOP. The TRAP state is absent, trap is tied to 0, and trap_clr is ignored.

## Structure
- Shared package alu_seq_pkg holds:
  - opcode constants;
  - op-class decode function (logic/shift/rotate/arith/compare/status);
  - state enum;
  - flag bit indices (ZERO=0, SIGN=1, CARRY=2).
- One sub-module, alu_flag_update: combinational merge of old status, op class, mode and ALU flags into the next status.

## Test plan
- ADD, full mode, a=0x7FFFF, b=0x00001 → wb_data=0x80000 in N+2; status {c,s,z} = 3'b010.
- INC, full mode, a=0xFFFFF → wb_data=0x00000; status = 3'b101.
- AND, half mode, a=0xFFFFF, b=0x003FF → wb_data=0x003FF; zero=0; sign and carry held from the prior value.
- SWP, a=0x12345, b=0x00ABC → wb_data=0x00ABC, wb_data2=0x12345, wb_two=1. Hold wb_ready=0 for 3 cycles → outputs stable and in_ready=0 throughout.
- LT, a=5, b=9 → sign=1, no wb_valid, in_ready=1 in N+2. Then assert rst_n=0 during a later EXEC → all outputs 0 immediately.
- Opcode 0x1F → with macro: trap=1, in_ready=0 until a trap_clr pulse, status unchanged. Without macro: behaves as NOP.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Opcodes, op classes, FSM states and status flag indices
//                shared by the ALU sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam int unsigned C_OP_NOP = 0,  C_OP_NOT = 1,  C_OP_AND = 2,  C_OP_OR  = 3;
  localparam int unsigned C_OP_XOR = 4,  C_OP_SHR = 5,  C_OP_SHL = 6,  C_OP_ROR = 7;
  localparam int unsigned C_OP_ROL = 8,  C_OP_SWP = 9,  C_OP_INC = 10, C_OP_DEC = 11;
  localparam int unsigned C_OP_ADD = 12, C_OP_ADC = 13, C_OP_SUB = 14, C_OP_SBC = 15;
  localparam int unsigned C_OP_EQ  = 16, C_OP_GT  = 17, C_OP_LT  = 18, C_OP_GE  = 19;
  localparam int unsigned C_OP_LE  = 20, C_OP_LSR = 21;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_SIGN  = 1;
  localparam int FLAG_CARRY = 2;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_LOGIC, CLS_SHIFT, CLS_ROT, CLS_ARITH, CLS_CMP, CLS_STATUS, CLS_ILLEGAL
  } op_class_e;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB, ST_TRAP} state_e;

  // Opcodes are grouped in contiguous ranges, so range compares decode the class.
  function automatic op_class_e op_class(input int unsigned op);
    if (op == C_OP_NOP)      return CLS_NONE;
    else if (op <= C_OP_XOR) return CLS_LOGIC;
    else if (op <= C_OP_SHL) return CLS_SHIFT;
    else if (op <= C_OP_SWP) return CLS_ROT;
    else if (op <= C_OP_SBC) return CLS_ARITH;
    else if (op <= C_OP_LE)  return CLS_CMP;
    else if (op == C_OP_LSR) return CLS_STATUS;
    else                     return CLS_ILLEGAL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_flag_update.sv
// ============================================================================
//  Module      : alu_flag_update
//  Description : Merges old status, op class, mode and ALU flags into the
//                next {carry, sign, zero} status value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_flag_update
  import alu_seq_pkg::*;
(
  input  logic [2:0] i_status,
  input  op_class_e  i_cls,
  input  logic       i_mode,
  input  logic       i_msb_full,
  input  logic       i_msb_half,
  input  logic       i_zero,
  input  logic       i_sign,
  input  logic       i_carry,
  output logic [2:0] o_status
);

  always_comb begin
    o_status = i_status;
    case (i_cls)
      CLS_LOGIC: o_status[FLAG_ZERO] = i_zero;
      CLS_SHIFT: begin
        o_status[FLAG_ZERO]  = i_zero;
        o_status[FLAG_CARRY] = i_carry;
      end
      // Arithmetic sign comes from the result MSB of the active word size.
      CLS_ARITH: begin
        o_status[FLAG_ZERO]  = i_zero;
        o_status[FLAG_CARRY] = i_carry;
        o_status[FLAG_SIGN]  = i_mode ? i_msb_full : i_msb_half;
      end
      CLS_CMP: begin
        o_status[FLAG_ZERO] = i_zero;
        o_status[FLAG_SIGN] = i_sign;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
//  Module      : alu_seq
//  Description : Instruction capture / execute / writeback sequencer in front
//                of the ALU; owns the status register. ALU_SEQ_TRAP_EN enables
//                the illegal-opcode trap state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_mode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_c,
  input  logic [WIDTH-1:0] alu_c2,
  input  logic             alu_zero,
  input  logic             alu_sign,
  input  logic             alu_carry,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] wb_data2,
  output logic             wb_two,
  output logic [2:0]       status,
  output logic             trap,
  input  logic             trap_clr
);

  state_e           r_state, w_state_next;
  logic             r_rdy;
  logic [OPW-1:0]   r_op;
  logic             r_mode;
  logic [WIDTH-1:0] r_a, r_b, r_wb_data, r_wb_data2;
  logic             r_wb_two;
  logic [2:0]       r_status, w_status_next;
  logic             w_accept, w_lsr, w_exec;
  op_class_e        w_in_cls, w_cls;

  assign w_in_cls = op_class(32'(in_op));
  assign w_cls    = op_class(32'(r_op));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_lsr        = 1'b0;
    w_exec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && r_rdy) begin
          w_accept = 1'b1;
          case (w_in_cls)
            CLS_NONE:    w_state_next = ST_IDLE;
            CLS_STATUS:  w_lsr        = 1'b1;
`ifdef ALU_SEQ_TRAP_EN
            CLS_ILLEGAL: w_state_next = ST_TRAP;
`else
            CLS_ILLEGAL: w_state_next = ST_IDLE;
`endif
            default:     w_state_next = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: begin
        w_exec       = 1'b1;
        w_state_next = (w_cls == CLS_CMP) ? ST_IDLE : ST_WB;
      end
      ST_WB: if (wb_ready) w_state_next = ST_IDLE;
`ifdef ALU_SEQ_TRAP_EN
      ST_TRAP: if (trap_clr) w_state_next = ST_IDLE;
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  alu_flag_update u_flags (
    .i_status   (r_status),
    .i_cls      (w_cls),
    .i_mode     (r_mode),
    .i_msb_full (alu_c[WIDTH-1]),
    .i_msb_half (alu_c[WIDTH/2-1]),
    .i_zero     (alu_zero),
    .i_sign     (alu_sign),
    .i_carry    (alu_carry),
    .o_status   (w_status_next)
  );

  // Ready is registered so it stays low for the first cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy      <= 1'b0;
      r_op       <= '0;
      r_mode     <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_wb_data  <= '0;
      r_wb_data2 <= '0;
      r_wb_two   <= 1'b0;
      r_status   <= '0;
    end else begin
      r_rdy <= (w_state_next == ST_IDLE);
      if (w_accept) begin
        r_op   <= in_op;
        r_mode <= in_mode;
        r_a    <= in_a;
        r_b    <= in_b;
      end
      if (w_lsr) r_status <= in_a[2:0];
      if (w_exec) begin
        r_wb_data  <= alu_c;
        r_wb_data2 <= alu_c2;
        r_wb_two   <= (32'(r_op) == C_OP_SWP);
        r_status   <= w_status_next;
      end
    end
  end

  assign in_ready = r_rdy;
  assign alu_op   = r_op;
  assign alu_mode = r_mode;
  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign alu_cin  = r_status[FLAG_CARRY];
  assign wb_valid = (r_state == ST_WB);
  assign wb_data  = r_wb_data;
  assign wb_data2 = r_wb_data2;
  assign wb_two   = r_wb_two;
  assign status   = r_status;

`ifdef ALU_SEQ_TRAP_EN
  assign trap = (r_state == ST_TRAP);
`else
  logic w_unused_trap_clr;
  assign w_unused_trap_clr = trap_clr;
  assign trap = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed self-checking bench for alu_seq with a small ALU model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_mode, wb_ready, trap_clr;
  logic [4:0]  in_op;
  logic [19:0] in_a, in_b;
  logic        in_ready, alu_mode, alu_cin, wb_valid, wb_two, trap;
  logic [4:0]  alu_op;
  logic [19:0] alu_a, alu_b, wb_data, wb_data2;
  logic [2:0]  status;
  logic [19:0] m_c, m_c2, msk;
  logic [20:0] sum;
  logic        m_z, m_s, m_cy;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(20), .OPW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_mode(in_mode), .in_a(in_a), .in_b(in_b),
    .alu_op(alu_op), .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_c(m_c), .alu_c2(m_c2), .alu_zero(m_z),
    .alu_sign(m_s), .alu_carry(m_cy), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_data2(wb_data2), .wb_two(wb_two), .status(status),
    .trap(trap), .trap_clr(trap_clr)
  );

  // Minimal ALU: only the ops exercised below.
  always_comb begin
    msk  = alu_mode ? 20'hFFFFF : 20'h003FF;
    sum  = '0;
    m_c  = '0;
    m_c2 = '0;
    m_z  = 1'b0;
    m_s  = 1'b0;
    m_cy = 1'b0;
    case (alu_op)
      5'd2:  m_c = alu_a & alu_b & msk;
      5'd9:  begin m_c = alu_b; m_c2 = alu_a; end
      5'd10: sum = {1'b0, alu_a & msk} + 21'd1;
      5'd12: sum = {1'b0, alu_a & msk} + {1'b0, alu_b & msk};
      5'd14: sum = {1'b0, alu_a & msk} - {1'b0, alu_b & msk};
      5'd18: begin m_s = (alu_a < alu_b); m_z = (alu_a == alu_b); end
      default: ;
    endcase
    if (alu_op inside {5'd10, 5'd12, 5'd14}) begin
      m_c  = sum[19:0] & msk;
      m_cy = alu_mode ? sum[20] : sum[10];
    end
    if (alu_op != 5'd18) m_z = (m_c == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic mode, input logic [19:0] a, input logic [19:0] b);
    in_valid = 1'b1; in_op = op; in_mode = mode; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_op = '0; in_mode = 1'b0;
    in_a = '0; in_b = '0; wb_ready = 1'b1; trap_clr = 1'b0;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_status",   32'(status),   32'h0);
    chk("rst_alu_op",   32'(alu_op),   32'h0);
    chk("rst_trap",     32'(trap),     32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(in_ready), 32'h1);

    // ADD full: 0x7FFFF + 1; INC is presented during WB and must wait.
    in_valid = 1'b1; in_op = 5'd12; in_mode = 1'b1; in_a = 20'h7FFFF; in_b = 20'h00001;
    tick();
    chk("add_exec_op",    32'(alu_op),   32'd12);
    chk("add_exec_ready", 32'(in_ready), 32'h0);
    chk("add_exec_wbv",   32'(wb_valid), 32'h0);
    in_op = 5'd10; in_a = 20'hFFFFF; in_b = 20'h0;
    tick();
    chk("add_wb_valid", 32'(wb_valid), 32'h1);
    chk("add_wb_data",  32'(wb_data),  32'h80000);
    chk("add_status",   32'(status),   32'h2);
    chk("add_wb_two",   32'(wb_two),   32'h0);
    tick();
    chk("add_wb_done",   32'(wb_valid), 32'h0);
    chk("inc_not_early", 32'(alu_op),   32'd12);
    chk("add_ready",     32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("inc_exec_op", 32'(alu_op), 32'd10);
    tick();
    chk("inc_wb_data", 32'(wb_data), 32'h0);
    chk("inc_status",  32'(status),  32'h5);
    chk("inc_cin",     32'(alu_cin), 32'h1);
    tick();

    // AND half mode: zero cleared, sign/carry held from INC.
    issue(5'd2, 1'b0, 20'hFFFFF, 20'h003FF);
    chk("and_mode", 32'(alu_mode), 32'h0);
    tick();
    chk("and_wb_data", 32'(wb_data), 32'h003FF);
    chk("and_status",  32'(status),  32'h4);
    tick();

    // SWP with writeback stalled for three cycles.
    wb_ready = 1'b0;
    issue(5'd9, 1'b1, 20'h12345, 20'h00ABC);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("swp_wb_valid", 32'(wb_valid), 32'h1);
      chk("swp_wb_data",  32'(wb_data),  32'h00ABC);
      chk("swp_wb_data2", 32'(wb_data2), 32'h12345);
      chk("swp_wb_two",   32'(wb_two),   32'h1);
      chk("swp_ready",    32'(in_ready), 32'h0);
      tick();
    end
    chk("swp_still_wb", 32'(wb_valid), 32'h1);
    chk("swp_status",   32'(status),   32'h4);
    wb_ready = 1'b1;
    tick();
    chk("swp_done_ready", 32'(in_ready), 32'h1);
    chk("swp_done_wbv",   32'(wb_valid), 32'h0);

    // LT: flags only, ready again in N+2.
    issue(5'd18, 1'b1, 20'd5, 20'd9);
    tick();
    chk("lt_wb_valid", 32'(wb_valid), 32'h0);
    chk("lt_ready",    32'(in_ready), 32'h1);
    chk("lt_status",   32'(status),   32'h6);

    // NOP: no bubble, status untouched.
    issue(5'd0, 1'b1, 20'h00055, 20'h0);
    chk("nop_ready",  32'(in_ready), 32'h1);
    chk("nop_status", 32'(status),   32'h6);
    chk("nop_wbv",    32'(wb_valid), 32'h0);

    // LSR: status loaded from in_a[2:0], visible in N+1.
    issue(5'd21, 1'b1, 20'h00003, 20'h0);
    chk("lsr_status", 32'(status),   32'h3);
    chk("lsr_ready",  32'(in_ready), 32'h1);

    // Illegal opcode.
    issue(5'd31, 1'b1, 20'h00007, 20'h0);
`ifdef ALU_SEQ_TRAP_EN
    chk("ill_trap",  32'(trap),     32'h1);
    chk("ill_ready", 32'(in_ready), 32'h0);
    tick();
    chk("ill_trap_hold", 32'(trap),   32'h1);
    chk("ill_status",    32'(status), 32'h3);
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    chk("ill_trap_clr", 32'(trap),     32'h0);
    chk("ill_ready2",   32'(in_ready), 32'h1);
`else
    chk("ill_trap",   32'(trap),     32'h0);
    chk("ill_ready",  32'(in_ready), 32'h1);
    chk("ill_status", 32'(status),   32'h3);
    chk("ill_wbv",    32'(wb_valid), 32'h0);
`endif

    // Asynchronous reset in the middle of EXEC.
    issue(5'd14, 1'b1, 20'd9, 20'd5);
    chk("sub_exec_op", 32'(alu_op), 32'd14);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_alu_op", 32'(alu_op),   32'h0);
    chk("arst_alu_a",  32'(alu_a),    32'h0);
    chk("arst_mode",   32'(alu_mode), 32'h0);
    chk("arst_status", 32'(status),   32'h0);
    chk("arst_ready",  32'(in_ready), 32'h0);
    chk("arst_wbv",    32'(wb_valid), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(in_ready), 32'h1);
    chk("post_rst_wbv",   32'(wb_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
